result_capture_fifo: RTL and testbench
======================================

Name: result_capture_fifo

Overview:
- Downstream stage of the 4-bit-in / 10-bit-out combinational datapath; consumes its 10-bit result words.
- Captures results via a valid/ready handshake into a small first-word-fall-through FIFO and releases them to the consumer in arrival order.
- Maintains an accepted-word counter and a rolling 16-bit signature so benches can compare whole result streams cheaply.

Parameters:
- DATA_W, 10, result word width; matches the upstream output_data width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 16, accepted-word counter width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream result word present.
- in_data  input  DATA_W  upstream result word (output_data of the upstream datapath).
- in_ready  output  1  FIFO can accept a word this cycle.
- out_valid  output  1  head word available.
- out_data  output  DATA_W  head word.
- out_ready  input  1  consumer takes head word this cycle.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- word_count  output  CNT_W  total words accepted since reset; saturates.
- signature  output  16  rolling signature of accepted words.

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst).
- Reset (rst=1 at a clock edge) clears the following, regardless of in-flight handshakes:
  - level=0, out_valid=0, out_data=0.
  - word_count=0, signature=0.
  - read/write pointers=0.
- While rst=1, in_ready=0. in_ready=1 from the first cycle after rst deasserts.
- A push occurs when in_valid && in_ready. A pop occurs when out_valid && out_ready.
- in_ready = (level != DEPTH), registered state only. It has no combinational path from out_ready, so a full FIFO rejects a word even while a pop happens in the same cycle.
- out_valid = (level != 0). out_data = mem[rd_ptr], driven from registered storage. Words pushed into an empty FIFO appear on out_data/out_valid the next cycle (latency 1).
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Level update per cycle:
  - push only: level+1.
  - pop only: level-1.
  - push and pop together (level between 1 and DEPTH-1): level unchanged; both pointers advance.
- Push with in_valid=0 or when full: no state change. Pop with empty or out_ready=0: no change.
- out_data holds its value while out_valid=1 and out_ready=0. in_data is ignored when in_ready=0.
- word_count increments on each push and saturates at 2^CNT_W-1 (no wrap).
- On each push: signature <= {signature[14:0], signature[15]} ^ {6'b0, in_data}. This is a rotate-left by 1, then XOR with the zero-extended word, for DATA_W=10. For other DATA_W, the word is zero-extended, or truncated to its 16 LSBs.
- Reset asserted mid-stream discards all stored words. A word presented in the reset cycle is not accepted.

Optional Feature:
- Macro RESULT_CAPTURE_SIG_EN.
- Defined: signature logic is built as specified.
- Undefined: signature register omitted; signature output tied to 16'h0000. All other behaviour is identical.

Test Plan:
- Reset release: hold rst 3 cycles with in_valid=1, in_data=10'h3FF -> in_ready=0 and level=0 throughout; after release, in_ready=1, out_valid=0, word_count=0, signature=0.
- Single word: push 10'h155 into empty FIFO, out_ready=0 -> next cycle out_valid=1, out_data=10'h155, level=1, word_count=1, signature=16'h0155.
- Fill and backpressure: push 10'h001, 10'h002, 10'h003, 10'h004 with out_ready=0 -> level=4, in_ready=0; a 5th word 10'h005 is not accepted and word_count stays 4. Drain with out_ready=1 -> outputs 1,2,3,4 in order, then out_valid=0.
- Simultaneous push/pop: at level=2, drive in_valid=1 and out_ready=1 for 6 cycles with words 10..15 -> level stays 2, all popped words in order. Pointers wrap without loss; word_count increases by 6.
- Signature sequence: from reset, push 10'h001 then 10'h002 -> signature=16'h0001, then 16'h0000 (0x0002^0x0002).
- Mid-stream reset: at level=3, assert rst 1 cycle with in_valid=1 -> level=0, out_valid=0, word_count=0. The next push of 10'h0AA appears as the head word.

Source files
------------

// File: rtl/result_capture_if.sv
// Handshake bundle between the upstream result producer, the capture FIFO and its consumer.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface result_capture_if #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic [LVL_W-1:0]  level;
   logic [CNT_W-1:0]  word_count;
   logic [15:0]       signature;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, level, word_count, signature
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, level, word_count, signature
   );
endinterface

// File: rtl/result_capture_fifo.sv
// First-word-fall-through capture FIFO for datapath result words, with a saturating accept counter.
// Define RESULT_CAPTURE_SIG_EN to build the rolling 16-bit signature; otherwise signature reads 0.
module result_capture_fifo #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   result_capture_if.slave   bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [CNT_W-1:0]  word_count_q, word_count_d;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

   assign full  = (level_q == LVL_W'(DEPTH));
   assign empty = (level_q == '0);

   // Ready comes from registered occupancy only, so a full FIFO never accepts
   // a word on the strength of a same-cycle pop.
   assign bus.in_ready  = ~rst & ~full;
   assign bus.out_valid = ~empty;
   assign bus.out_data  = mem_q[rd_ptr_q];
   assign bus.level      = level_q;
   assign bus.word_count = word_count_q;

   assign push = bus.in_valid & ~rst & ~full;
   assign pop  = bus.out_ready & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = bus.in_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
         level_d = level_q - LVL_W'(1);
      end
   end

   always_comb begin
      word_count_d = word_count_q;
      if (push && (word_count_q != {CNT_W{1'b1}})) begin
         word_count_d = word_count_q + CNT_W'(1);
      end
   end

   // Storage is cleared too so the head word reads zero straight out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q        <= '{default: '0};
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         word_count_q <= '0;
      end else begin
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         word_count_q <= word_count_d;
      end
   end

`ifdef RESULT_CAPTURE_SIG_EN
   logic [15:0] signature_q, signature_d;
   logic [15:0] word_ext;

   // Size cast zero-extends narrow words and keeps the 16 LSBs of wide ones.
   always_comb begin
      word_ext    = 16'(bus.in_data);
      signature_d = signature_q;
      if (push) begin
         signature_d = {signature_q[14:0], signature_q[15]} ^ word_ext;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         signature_q <= '0;
      end else begin
         signature_q <= signature_d;
      end
   end

   assign bus.signature = signature_q;
`else
   assign bus.signature = 16'h0000;
`endif

endmodule

// File: tb/tb_result_capture_fifo.sv
// Bench for result_capture_fifo: directed vector table for the documented scenarios,
// then randomized traffic checked against a queue-based reference model.
module tb_result_capture_fifo;
   localparam int DATA_W = 10;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   result_capture_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   result_capture_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit          rst;
      bit          iv;
      logic [9:0]  d;
      bit          ordy;
      int          lvl;
      bit          ov;
      bit          chk_od;
      logic [9:0]  od;
      bit          ir;
      int          cnt;
      logic [15:0] sig;
   } vec_t;

   vec_t tbl[$];

   // Reference model state
   int unsigned m_q[$];
   int unsigned m_cnt;
   int unsigned m_sig;

   function automatic logic [15:0] sx(input logic [15:0] v);
`ifdef RESULT_CAPTURE_SIG_EN
      return v;
`else
      return 16'h0000;
`endif
   endfunction

   function automatic void add(input bit r, input bit iv, input logic [9:0] d, input bit ordy,
                               input int lvl, input bit ov, input bit chk_od, input logic [9:0] od,
                               input bit ir, input int cnt, input logic [15:0] sig);
      vec_t v;
      v.rst = r; v.iv = iv; v.d = d; v.ordy = ordy; v.lvl = lvl; v.ov = ov;
      v.chk_od = chk_od; v.od = od; v.ir = ir; v.cnt = cnt; v.sig = sx(sig);
      tbl.push_back(v);
   endfunction

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit r, input bit iv, input logic [9:0] d, input bit ordy);
      rst           = r;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
   endtask

   // Advances the model by one clock using the inputs currently applied.
   task automatic model_step();
      bit do_push, do_pop;
      if (rst) begin
         m_q.delete();
         m_cnt = 0;
         m_sig = 0;
      end else begin
         do_push = bus.in_valid && (m_q.size() < DEPTH);
         do_pop  = bus.out_ready && (m_q.size() > 0);
         if (do_pop) void'(m_q.pop_front());
         if (do_push) begin
            m_q.push_back(int'(bus.in_data));
            if (m_cnt < (2 ** CNT_W) - 1) m_cnt++;
            m_sig = (((m_sig * 2) % 65536) + (m_sig / 32768)) ^ int'(bus.in_data);
         end
      end
   endtask

   initial begin
      drive(1'b1, 1'b0, '0, 1'b0);

      // reset held with a word present
      add(1, 1, 10'h3FF, 0,  0, 0, 1, 10'h000, 0,  0, 16'h0000);
      add(1, 1, 10'h3FF, 0,  0, 0, 1, 10'h000, 0,  0, 16'h0000);
      add(1, 1, 10'h3FF, 0,  0, 0, 1, 10'h000, 0,  0, 16'h0000);
      add(0, 0, 10'h000, 0,  0, 0, 1, 10'h000, 1,  0, 16'h0000);
      // single word
      add(0, 1, 10'h155, 0,  1, 1, 1, 10'h155, 1,  1, 16'h0155);
      add(1, 1, 10'h3FF, 0,  0, 0, 1, 10'h000, 0,  0, 16'h0000);
      // fill, then full with a rejected word (also alongside a pop)
      add(0, 1, 10'h001, 0,  1, 1, 1, 10'h001, 1,  1, 16'h0001);
      add(0, 1, 10'h002, 0,  2, 1, 1, 10'h001, 1,  2, 16'h0000);
      add(0, 1, 10'h003, 0,  3, 1, 1, 10'h001, 1,  3, 16'h0003);
      add(0, 1, 10'h004, 0,  4, 1, 1, 10'h001, 0,  4, 16'h0002);
      add(0, 1, 10'h005, 0,  4, 1, 1, 10'h001, 0,  4, 16'h0002);
      add(0, 1, 10'h005, 1,  3, 1, 1, 10'h002, 1,  4, 16'h0002);
      add(0, 0, 10'h000, 1,  2, 1, 1, 10'h003, 1,  4, 16'h0002);
      add(0, 0, 10'h000, 1,  1, 1, 1, 10'h004, 1,  4, 16'h0002);
      add(0, 0, 10'h000, 1,  0, 0, 0, 10'h000, 1,  4, 16'h0002);
      // reach level 2, then six simultaneous push/pop cycles across pointer wrap
      add(0, 1, 10'h008, 0,  1, 1, 1, 10'h008, 1,  5, 16'h000C);
      add(0, 1, 10'h009, 0,  2, 1, 1, 10'h008, 1,  6, 16'h0011);
      add(0, 1, 10'h00A, 1,  2, 1, 1, 10'h009, 1,  7, 16'h0028);
      add(0, 1, 10'h00B, 1,  2, 1, 1, 10'h00A, 1,  8, 16'h005B);
      add(0, 1, 10'h00C, 1,  2, 1, 1, 10'h00B, 1,  9, 16'h00BA);
      add(0, 1, 10'h00D, 1,  2, 1, 1, 10'h00C, 1, 10, 16'h0179);
      add(0, 1, 10'h00E, 1,  2, 1, 1, 10'h00D, 1, 11, 16'h02FC);
      add(0, 1, 10'h00F, 1,  2, 1, 1, 10'h00E, 1, 12, 16'h05F7);
      // mid-stream reset at level 3
      add(0, 1, 10'h020, 0,  3, 1, 1, 10'h00E, 1, 13, 16'h0BCE);
      add(1, 1, 10'h3FF, 0,  0, 0, 1, 10'h000, 0,  0, 16'h0000);
      add(0, 1, 10'h0AA, 0,  1, 1, 1, 10'h0AA, 1,  1, 16'h00AA);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].ordy);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d level", i),      bus.level,      tbl[i].lvl);
         check($sformatf("vec%0d out_valid", i),  bus.out_valid,  tbl[i].ov);
         if (tbl[i].chk_od)
            check($sformatf("vec%0d out_data", i), bus.out_data,  tbl[i].od);
         check($sformatf("vec%0d in_ready", i),   bus.in_ready,   tbl[i].ir);
         check($sformatf("vec%0d word_count", i), bus.word_count, tbl[i].cnt);
         check($sformatf("vec%0d signature", i),  bus.signature,  tbl[i].sig);
      end

      // randomized traffic against the model, starting from a reset
      drive(1'b1, 1'b0, '0, 1'b0);
      model_step();
      @(posedge clk);
      #1;
      for (int c = 0; c < 3000; c++) begin
         drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
               10'($urandom), ($urandom_range(0, 2) != 0));
         model_step();
         @(posedge clk);
         #1;
         check($sformatf("rnd%0d level", c),     bus.level,     m_q.size());
         check($sformatf("rnd%0d out_valid", c), bus.out_valid, (m_q.size() != 0));
         if (m_q.size() != 0)
            check($sformatf("rnd%0d out_data", c), bus.out_data, m_q[0]);
         check($sformatf("rnd%0d in_ready", c),  bus.in_ready,
               (!rst && (m_q.size() < DEPTH)));
         check($sformatf("rnd%0d word_count", c), bus.word_count, m_cnt);
         check($sformatf("rnd%0d signature", c),  bus.signature,  sx(16'(m_sig)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
